// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped cache request controller.
// Row/put layouts match the single-cycle array this block drives.
package cache_pkg;

    localparam int TAG_W  = 18;
    localparam int IDX_W  = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int SETS   = 1 << IDX_W;
    localparam int ROW_W  = TAG_W + DATA_W + 2;
    localparam int REQ_W  = BE_W + TAG_W + IDX_W + DATA_W + 3;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_e;

    typedef struct packed {
        logic [BE_W-1:0]   byte_en;
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
        logic              msi_valid;
        logic [1:0]        msi;
    } cache_req_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [1:0]        msi;
    } cache_row_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_RF_REQ,
        ST_RF_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cache_ctrl_if.sv
// Core, memory and array-side signals of the cache controller.
// slave = controller side, master = environment side.
interface cache_ctrl_if;
    import cache_pkg::*;

    logic              core_req_valid;
    logic              core_req_ready;
    logic [31:0]       core_req_addr;
    logic [BE_W-1:0]   core_req_byte_en;
    logic [DATA_W-1:0] core_req_data;
    logic              core_resp_valid;
    logic              core_resp_ready;
    logic [DATA_W-1:0] core_resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic [BE_W-1:0]   mem_req_byte_en;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_resp_data;
    logic              cache_put_valid;
    cache_req_t        cache_put_request;
    logic [ROW_W-1:0]  cache_row;

    modport slave (
        input  core_req_valid, core_req_addr,
        input  core_req_byte_en, core_req_data,
        input  core_resp_ready,
        input  mem_req_ready, mem_resp_valid,
        input  mem_resp_data, cache_row,
        output core_req_ready, core_resp_valid,
        output core_resp_data,
        output mem_req_valid, mem_req_addr,
        output mem_req_byte_en, mem_req_data,
        output mem_resp_ready,
        output cache_put_valid, cache_put_request
    );

    modport master (
        output core_req_valid, core_req_addr,
        output core_req_byte_en, core_req_data,
        output core_resp_ready,
        output mem_req_ready, mem_resp_valid,
        output mem_resp_data, cache_row,
        input  core_req_ready, core_resp_valid,
        input  core_resp_data,
        input  mem_req_valid, mem_req_addr,
        input  mem_req_byte_en, mem_req_data,
        input  mem_resp_ready,
        input  cache_put_valid, cache_put_request
    );

endinterface

// File: rtl/cache_addr_split.sv
// Splits a byte address into tag / set index / word offset.
// Shared with the array wrapper so both agree on the layout.
module cache_addr_split
    import cache_pkg::*;
(
    input  logic [31:0]      addr_i,
    output logic [TAG_W-1:0] tag_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [1:0]       off_o
);

    assign tag_o = addr_i[31 -: TAG_W];
    assign idx_o = addr_i[IDX_W+1:2];
    assign off_o = addr_i[1:0];

endmodule

// File: rtl/cache_ctrl.sv
// Request-side controller for a direct-mapped MSI cache array:
// hit/miss check, dirty writeback, refill and post-reset sweep.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    cache_ctrl_if.slave bus
);

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [TAG_W-1:0]  in_tag;
    logic [IDX_W-1:0]  in_idx;
    logic [1:0]        in_off;

    cache_addr_split u_split (
        .addr_i (bus.core_req_addr),
        .tag_o  (in_tag),
        .idx_o  (in_idx),
        .off_o  (in_off)
    );

    logic unused_off;
    assign unused_off = ^in_off;

    cache_row_t row;
    logic       hit;
    logic       is_load;

    assign row     = bus.cache_row;
    assign hit     = (row.msi != MSI_I) && (row.tag == tag_q);
    assign is_load = (be_q == '0);

    cache_req_t        put;
    logic              put_v;
    logic              req_rdy;
    logic              resp_v;
    logic              mreq_v;
    logic              mresp_rdy;
    logic [31:0]       maddr;
    logic [BE_W-1:0]   mbe;
    logic [DATA_W-1:0] mdata;

    always_comb begin
        put.byte_en   = '0;
        put.tag       = tag_q;
        put.index     = idx_q;
        put.data      = wdata_q;
        put.msi_valid = 1'b0;
        put.msi       = MSI_I;
        put_v         = 1'b0;
        req_rdy       = 1'b0;
        resp_v        = 1'b0;
        mreq_v        = 1'b0;
        mresp_rdy     = 1'b0;
        maddr         = {tag_q, idx_q, 2'b00};
        mbe           = '0;
        mdata         = '0;
        unique case (state_q)
            ST_INIT: begin
                put_v         = 1'b1;
                put.byte_en   = '1;
                put.tag       = '0;
                put.index     = cnt_q;
                put.data      = '0;
                put.msi_valid = 1'b1;
                put.msi       = MSI_I;
                mresp_rdy     = 1'b1;
            end
            ST_IDLE: req_rdy = 1'b1;
            ST_LOOKUP: begin
                // store hit upgrades S to M without a bus transaction
                if (hit && !is_load) begin
                    put_v         = 1'b1;
                    put.byte_en   = be_q;
                    put.msi_valid = 1'b1;
                    put.msi       = MSI_M;
                end
            end
            ST_WB: begin
                mreq_v = 1'b1;
                maddr  = {row.tag, idx_q, 2'b00};
                mbe    = '1;
                mdata  = row.data;
            end
            ST_RF_REQ: mreq_v = 1'b1;
            ST_RF_WAIT: begin
                mresp_rdy = 1'b1;
                if (bus.mem_resp_valid) begin
                    put_v         = 1'b1;
                    put.byte_en   = '1;
                    put.data      = bus.mem_resp_data;
                    put.msi_valid = 1'b1;
                    put.msi       = MSI_S;
                end
            end
            ST_RESP: resp_v = 1'b1;
            default: ;
        endcase
    end

    assign bus.core_req_ready    = req_rdy & ~RST;
    assign bus.core_resp_valid   = resp_v & ~RST;
    assign bus.core_resp_data    = RST ? '0 : rdata_q;
    assign bus.mem_req_valid     = mreq_v & ~RST;
    assign bus.mem_req_addr      = maddr;
    assign bus.mem_req_byte_en   = mbe;
    assign bus.mem_req_data      = mdata;
    assign bus.mem_resp_ready    = mresp_rdy & ~RST;
    assign bus.cache_put_valid   = put_v & ~RST;
    assign bus.cache_put_request = put;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.core_req_valid) begin
                        tag_q   <= in_tag;
                        idx_q   <= in_idx;
                        be_q    <= bus.core_req_byte_en;
                        wdata_q <= bus.core_req_data;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        rdata_q <= is_load ? row.data : '0;
                        state_q <= ST_RESP;
                    end else if (row.msi == MSI_M) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_RF_REQ;
                    end
                end
                ST_WB: begin
                    if (bus.mem_req_ready) state_q <= ST_RF_REQ;
                end
                ST_RF_REQ: begin
                    if (bus.mem_req_ready) state_q <= ST_RF_WAIT;
                end
                ST_RF_WAIT: begin
                    if (bus.mem_resp_valid) state_q <= ST_LOOKUP;
                end
                ST_RESP: begin
                    if (bus.core_resp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: array and memory models, directed table,
// multi-cycle corner sequences and a randomized coherence check.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if bus ();

    cache_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return ({2'b00, a[31:2]} * 32'h9E3779B1) ^ 32'hC001D00D;
    endfunction

    // cache array model
    logic [TAG_W-1:0]  a_tag  [SETS];
    logic [DATA_W-1:0] a_data [SETS];
    logic [1:0]        a_msi  [SETS];
    cache_req_t preq;
    bit init_win = 0;
    int stray = 0;

    assign preq = bus.cache_put_request;
    assign bus.cache_row = {a_tag[preq.index], a_data[preq.index],
                            a_msi[preq.index]};

    always @(posedge clk) begin
        if (bus.cache_put_valid) begin
            a_tag[preq.index]  <= preq.tag;
            a_data[preq.index] <= merge(a_data[preq.index], preq.data,
                                        preq.byte_en);
            if (preq.msi_valid) a_msi[preq.index] <= preq.msi;
            if (init_win && preq.msi != MSI_I) stray <= stray + 1;
        end
    end

    // memory model
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } mlog_t;

    logic [31:0] back [int unsigned];
    mlog_t mlog[$];
    mlog_t prev;
    int n_rd = 0, n_wr = 0;
    int mem_stall = 0, resp_delay = 2, stab_bad = 0;
    bit rd_pend = 0, rsp_fire = 0, pw = 0;
    int rd_dly = 0;
    logic [31:0] rd_dat;

    function automatic logic [31:0] back_rd(input logic [31:0] a);
        if (back.exists(a >> 2)) return back[a >> 2];
        return init_val(a);
    endfunction

    initial begin
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rsp_fire) begin
                bus.mem_resp_valid = 1'b0;
                rd_pend = 0;
                rsp_fire = 0;
            end
            if (rd_pend && !bus.mem_resp_valid) begin
                if (rd_dly <= 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = rd_dat;
                end else rd_dly--;
            end
            #1;
            if (bus.mem_req_valid && mem_stall > 0) begin
                bus.mem_req_ready = 1'b0;
                mem_stall--;
            end else bus.mem_req_ready = 1'b1;
            #1;
            if (pw && !rst) begin
                if (!bus.mem_req_valid || bus.mem_req_addr != prev.addr ||
                    bus.mem_req_byte_en != prev.be ||
                    bus.mem_req_data != prev.data) stab_bad++;
            end
            pw = bus.mem_req_valid && !bus.mem_req_ready;
            prev = '{bus.mem_req_addr, bus.mem_req_byte_en, bus.mem_req_data};
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                mlog.push_back(prev);
                if (prev.be == 4'hF) begin
                    back[prev.addr >> 2] = prev.data;
                    n_wr++;
                end else begin
                    n_rd++;
                    rd_pend = 1;
                    rd_dly = resp_delay;
                    rd_dat = back_rd(prev.addr);
                end
            end
            if (bus.mem_resp_valid && bus.mem_resp_ready) rsp_fire = 1;
        end
    end

    task automatic init_sweep();
        int bad;
        bad = 0;
        init_win = 1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            #1;
            if (bus.core_req_ready || !bus.cache_put_valid ||
                preq.index != IDX_W'(i) || preq.msi != MSI_I ||
                preq.byte_en != 4'hF || preq.data != '0) bad++;
            @(negedge clk);
        end
        #1;
        chk(bad == 0, "init sweep", bad, 0);
        chk(bus.core_req_ready == 1'b1, "ready after sweep",
            32'(bus.core_req_ready), 1);
        init_win = 0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input int hold,
                         output logic [31:0] rdata, output int lat);
        int n, bad;
        rdata = '0;
        lat = -1;
        bus.core_resp_ready = (hold == 0);
        @(negedge clk);
        bus.core_req_valid   = 1'b1;
        bus.core_req_addr    = a;
        bus.core_req_byte_en = be;
        bus.core_req_data    = d;
        n = 0;
        #1;
        while (!bus.core_req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.core_req_ready) begin
            chk(0, "accept timeout", a, 1);
            bus.core_req_valid = 1'b0;
            bus.core_resp_ready = 1'b1;
            return;
        end
        @(negedge clk);
        bus.core_req_valid   = 1'b0;
        bus.core_req_addr    = $urandom;
        bus.core_req_byte_en = 4'($urandom);
        bus.core_req_data    = $urandom;
        n = 1;
        #1;
        while (!bus.core_resp_valid && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.core_resp_valid) begin
            chk(0, "resp timeout", a, 1);
            bus.core_resp_ready = 1'b1;
            return;
        end
        lat = n;
        rdata = bus.core_resp_data;
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                if (!bus.core_resp_valid || bus.core_resp_data != rdata ||
                    bus.core_req_ready) bad++;
                @(negedge clk);
                #1;
            end
            bus.core_resp_ready = 1'b1;
            chk(bad == 0, "resp hold stable", bad, 0);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
        int          rd;
        int          wr;
        int          lat;
        logic [1:0]  msi;
    } vec_t;

    vec_t tv[6];
    logic [31:0] ref_m [int unsigned];

    initial begin
        logic [31:0] r;
        int l, r0, w0, n0, t;
        logic [11:0] ix;
        rst = 1'b1;
        bus.core_req_valid   = 1'b0;
        bus.core_req_addr    = '0;
        bus.core_req_byte_en = '0;
        bus.core_req_data    = '0;
        bus.core_resp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk({bus.core_req_ready, bus.core_resp_valid, bus.mem_req_valid,
             bus.cache_put_valid} == 4'b0, "reset valids",
            {28'b0, bus.core_req_ready, bus.core_resp_valid,
             bus.mem_req_valid, bus.cache_put_valid}, 0);
        chk(bus.core_resp_data == '0, "reset resp data",
            bus.core_resp_data, 0);
        init_sweep();

        back[32'h1000 >> 2]     = 32'hDEADBEEF;
        back[32'h0040_1000 >> 2] = 32'h12345678;
        tv[0] = '{32'h1000, 4'h0, 0, 32'hDEADBEEF, 1, 0, -1, MSI_S};
        tv[1] = '{32'h1000, 4'h0, 0, 32'hDEADBEEF, 0, 0, 2, MSI_S};
        tv[2] = '{32'h1000, 4'b0011, 32'h5555, 0, 0, 0, 2, MSI_M};
        tv[3] = '{32'h1000, 4'h0, 0, 32'hDEAD5555, 0, 0, 2, MSI_M};
        tv[4] = '{32'h2004, 4'h0, 0, init_val(32'h2004), 1, 0, -1, MSI_S};
        tv[5] = '{32'h0040_1000, 4'h0, 0, 32'h12345678, 1, 1, -1, MSI_S};
        for (int i = 0; i < 6; i++) begin
            r0 = n_rd;
            w0 = n_wr;
            do_op(tv[i].addr, tv[i].be, tv[i].data, 0, r, l);
            chk(r == tv[i].exp, $sformatf("v%0d data", i), r, tv[i].exp);
            chk(n_rd - r0 == tv[i].rd, $sformatf("v%0d rd", i),
                n_rd - r0, tv[i].rd);
            chk(n_wr - w0 == tv[i].wr, $sformatf("v%0d wr", i),
                n_wr - w0, tv[i].wr);
            if (tv[i].lat >= 0)
                chk(l == tv[i].lat, $sformatf("v%0d lat", i), l, tv[i].lat);
            ix = tv[i].addr[13:2];
            chk(a_msi[ix] == tv[i].msi, $sformatf("v%0d msi", i),
                a_msi[ix], tv[i].msi);
        end
        n0 = mlog.size();
        chk(mlog[n0-2].addr == 32'h1000 && mlog[n0-2].be == 4'hF,
            "wb addr", mlog[n0-2].addr, 32'h1000);
        chk(mlog[n0-2].data == 32'hDEAD5555, "wb data",
            mlog[n0-2].data, 32'hDEAD5555);
        chk(mlog[n0-1].addr == 32'h0040_1000 && mlog[n0-1].be == 4'h0,
            "rf addr", mlog[n0-1].addr, 32'h0040_1000);
        chk(a_tag[12'h400] == 18'h100, "rf tag", a_tag[12'h400], 18'h100);

        // backpressure on both memory request and core response
        mem_stall = 5;
        do_op(32'h3008, 4'h0, 0, 3, r, l);
        chk(r == init_val(32'h3008), "bp load", r, init_val(32'h3008));
        do_op(32'h3008, 4'hF, 32'hCAFEF00D, 0, r, l);
        chk(r == 0, "bp store resp", r, 0);
        mem_stall = 5;
        w0 = n_wr;
        do_op(32'h0040_3008, 4'h0, 0, 3, r, l);
        chk(r == init_val(32'h0040_3008), "bp conflict", r,
            init_val(32'h0040_3008));
        chk(n_wr - w0 == 1 && back_rd(32'h3008) == 32'hCAFEF00D,
            "bp wb data", back_rd(32'h3008), 32'hCAFEF00D);
        chk(mem_stall == 0, "stall consumed", mem_stall, 0);
        chk(stab_bad == 0, "mem req stable", stab_bad, 0);

        // reset while waiting for refill data
        resp_delay = 8;
        n0 = mlog.size();
        @(negedge clk);
        bus.core_req_valid   = 1'b1;
        bus.core_req_addr    = 32'h6010;
        bus.core_req_byte_en = 4'h0;
        t = 0;
        #1;
        while (mlog.size() == n0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(mlog.size() > n0, "reach rf_wait", mlog.size(), n0 + 1);
        bus.core_req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk(bus.mem_resp_ready == 1'b1, "rf_wait ready",
            32'(bus.mem_resp_ready), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk({bus.core_req_ready, bus.core_resp_valid, bus.mem_req_valid,
             bus.cache_put_valid, bus.mem_resp_ready} == 5'b0,
            "mid reset valids",
            {27'b0, bus.core_req_ready, bus.core_resp_valid,
             bus.mem_req_valid, bus.cache_put_valid,
             bus.mem_resp_ready}, 0);
        init_sweep();
        chk(!rd_pend, "stale resp drained", 32'(rd_pend), 0);
        chk(stray == 0, "stale resp not written", stray, 0);
        resp_delay = 2;
        r0 = n_rd;
        do_op(32'h6010, 4'h0, 0, 0, r, l);
        chk(n_rd - r0 == 1, "post reset miss", n_rd - r0, 1);
        chk(r == init_val(32'h6010), "post reset data", r,
            init_val(32'h6010));

        // randomized loads/stores over conflicting lines
        for (int k = 0; k < 300; k++) begin
            logic [17:0] tg;
            logic [31:0] a, d, e, w;
            logic [3:0] be;
            int hold;
            tg = 18'(8 + $urandom_range(0, 3));
            a = {tg, 12'($urandom_range(0, 3)), 2'($urandom)};
            be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            d = $urandom;
            mem_stall = $urandom_range(0, 2);
            resp_delay = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            w = ref_m.exists(a >> 2) ? ref_m[a >> 2] : init_val(a);
            do_op(a, be, d, hold, r, l);
            if (be == 4'h0) begin
                chk(r == w, "rand load", r, w);
            end else begin
                e = merge(w, d, be);
                ref_m[a >> 2] = e;
                chk(r == 0, "rand store resp", r, 0);
            end
        end
        chk(stab_bad == 0, "mem req stable all", stab_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Request-side controller directly upstream of the single-cycle direct-mapped cache array (4096 sets, 18-bit tag, 32-bit word, 2-bit MSI flag).
- Accepts word loads/stores from the core and drives the array's put_valid/put_request.
- Checks the array's combinational row response for hit/miss, writes back dirty victims to memory and refills on miss.
- After reset, sweeps the array to Invalid.

Parameters:
- TAG_W, 18, tag width
- IDX_W, 12, index width; set count = 1<<IDX_W
- DATA_W, 32, word width
- BE_W, 4, byte-enable width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- core_req_valid  in  1  core request valid
- core_req_ready  out  1  controller can accept
- core_req_addr  in  32  byte address; bits[1:0] ignored
- core_req_byte_en  in  4  0000 = load, else store mask
- core_req_data  in  32  store data
- core_resp_valid  out  1  response valid
- core_resp_ready  in  1  core accepts response
- core_resp_data  out  32  load data; 0 for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts
- mem_req_addr  out  32  {tag,index,2'b00}
- mem_req_byte_en  out  4  1111 write, 0000 read
- mem_req_data  out  32  writeback data
- mem_resp_valid  in  1  read data valid
- mem_resp_ready  out  1  controller accepts read data
- mem_resp_data  in  32  refill word
- cache_put_valid  out  1  write enable to array
- cache_put_request  out  69  {byte_en4, tag18, index12, data32, msi_valid1, msi2}
- cache_row  in  52  {tag18, data32, msi2}; combinational, indexed by cache_put_request index field

Behaviour:
- MSI encoding: I=00, S=01, M=10. Hit = row.msi != I and row.tag == latched tag.
- States: INIT, IDLE, LOOKUP, WB, RF_REQ, RF_WAIT, RESP.
- Reset (any cycle, mid-operation included): state <= INIT, init counter <= 0. Outputs forced low: core_req_ready, core_resp_valid, mem_req_valid, cache_put_valid. core_resp_data = 0. Outstanding request dropped.
- INIT: cache_put_valid=1 with byte_en=1111, tag=0, data=0, msi_valid=1, msi=I, index=counter. Lasts 4096 cycles; counter wraps 4095 -> IDLE. mem_resp_ready=1 here, so stale responses are drained and discarded.
- IDLE: core_req_ready=1. On valid&&ready, latch addr/byte_en/data -> LOOKUP.
- LOOKUP (one cycle): drive index from latched addr, put_valid=0.
  - Load hit: resp_data <= row.data -> RESP.
  - Store hit: put_valid=1, byte_en=latched mask, tag=latched tag, msi_valid=1, msi=M (S upgrades to M locally) -> RESP with resp_data=0.
  - Miss with victim M -> WB.
  - Miss with victim I or S -> RF_REQ.
- WB: mem_req write, addr={row.tag, index, 00}, byte_en=1111, data=row.data. Held stable until mem_req_ready -> RF_REQ.
- RF_REQ: mem_req read, addr={latched tag, index, 00}, byte_en=0000. Held until ready -> RF_WAIT.
- RF_WAIT: mem_resp_ready=1. On mem_resp_valid, write row: byte_en=1111, tag, data=mem_resp_data, msi_valid=1, msi=S -> LOOKUP (replay, guaranteed hit).
- RESP: core_resp_valid=1, data stable until core_resp_ready -> IDLE. No new request accepted in the same cycle (one outstanding).
- Latency: hit = accept at edge N, core_resp_valid high in cycle N+2. Clean miss adds 1 + memory round trip + 1 replay cycle; dirty miss adds the writeback handshake on top.
- The array is never written when put_valid=0. Store mask merging is done by the array; the controller passes the raw mask.

Decomposition:
- Package cache_pkg holds: TAG_W/IDX_W/DATA_W/BE_W, MSI enum (I/S/M), cache_req_t (69-bit packed), cache_row_t (52-bit packed), and the FSM state enum.
- No sub-module required. The single optional one is cache_addr_split (combinational address to tag/index/offset), shared with the array wrapper.

Test Plan:
- Reset then idle: core_req_ready=0 for exactly 4096 cycles, cache_put_valid=1 each cycle with index 0..4095, then ready=1.
- Load 0x0000_1000 cold: miss, mem read addr 0x0000_1000; mem returns 0xDEADBEEF; core_resp_data=0xDEADBEEF; repeated load hits with resp at N+2 and no mem traffic.
- Store 0x0000_1000 be=0011 data=0x0000_5555 after the fill above: put with msi=M; next load returns 0xDEAD5555.
- Conflict load 0x0040_1000 (same index, tag differs) with dirty line: mem write addr 0x0000_1000 data 0xDEAD5555 be=1111, then read 0x0040_1000, row state S.
- Backpressure: mem_req_ready low 5 cycles and core_resp_ready low 3 cycles -> all request/response fields stable while valid is held.
- RST asserted in RF_WAIT: next cycle state INIT, all valids low; a mem_resp arriving during INIT is consumed and not written to the array.
